// File: rtl/muldiv_seq_32.sv
`default_nettype none
// ============================================================================
// muldiv_seq_32 : iterative 32-bit MULT/MULTU/DIV/DIVU unit, 32 iterations,
// sign fix-up cycle, one-cycle HI/LO write enables. Rev 1.0
// ============================================================================
module muldiv_seq_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             squashn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             stalled,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             hi_en,
  output logic             lo_en
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [4:0]         r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic               r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_load;
  logic               w_signed;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH:0]   w_shift;
  logic [WIDTH:0]     w_rem;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  assign w_accept = start & squashn;
  assign w_load   = ((r_state == S_IDLE) || (r_state == S_DONE)) && w_accept;
  assign w_signed = ~op[0];
  assign w_mag_a  = (w_signed && opA[WIDTH-1]) ? -opA : opA;
  assign w_mag_b  = (w_signed && opB[WIDTH-1]) ? -opB : opB;

  assign stalled  = w_load || (r_state == S_RUN) || (r_state == S_FIX);
  assign hi_en    = (r_state == S_DONE) && squashn;
  assign lo_en    = (r_state == S_DONE) && squashn;
  assign hi       = r_hi;
  assign lo       = r_lo;

  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring divide: the shifted partial remainder needs one extra bit.
  assign w_shift    = {r_acc, 1'b0};
  assign w_rem      = w_shift[2*WIDTH:WIDTH];
  assign w_diff     = w_rem - {1'b0, r_b};
  assign w_div_next = w_diff[WIDTH] ? {w_rem[WIDTH-1:0], w_shift[WIDTH-1:1], 1'b0}
                                    : {w_diff[WIDTH-1:0], w_shift[WIDTH-1:1], 1'b1};

  assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
  assign w_quo_fix  = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem_fix  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN: begin
        if (!squashn)              w_next = S_IDLE;
        else if (r_count == 5'd31) w_next = S_FIX;
      end
      S_FIX:  w_next = squashn ? S_DONE : S_IDLE;
      S_DONE: w_next = w_accept ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= 5'd0;
      r_acc   <= '0;
      r_b     <= '0;
      r_div   <= 1'b0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (w_load) begin
        r_count <= 5'd0;
        r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
        r_b     <= w_mag_b;
        r_div   <= op[1];
        r_neg_q <= w_signed && (opA[WIDTH-1] ^ opB[WIDTH-1]);
        r_neg_r <= w_signed && opA[WIDTH-1];
        r_dz    <= (opB == '0);
      end else if (r_state == S_RUN) begin
        r_count <= r_count + 5'd1;
        r_acc   <= r_div ? w_div_next : w_mul_next;
      end
      if ((r_state == S_FIX) && squashn) begin
        if (r_div) begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end else begin
          r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
          r_lo <= w_prod_fix[WIDTH-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire
